// File: rtl/instruction_cache_pkg.sv
// Shared definitions for the instruction cache slice.
//   - default geometry (NUM_BLOCKS, WORDS_PER_BLOCK)
//   - derived address-field widths for that default geometry
//   - refill FSM state encoding
package instruction_cache_pkg;

  localparam int DEFAULT_NUM_BLOCKS      = 8;
  localparam int DEFAULT_WORDS_PER_BLOCK = 4;

  localparam int INDEX_W    = $clog2(DEFAULT_NUM_BLOCKS);
  localparam int OFFSET_W   = $clog2(DEFAULT_WORDS_PER_BLOCK);
  localparam int TAG_W      = 32 - 2 - OFFSET_W - INDEX_W;
  localparam int BLK_ADDR_W = 32 - 2 - OFFSET_W;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_MEM_READ,
    ST_UPDATE
  } cache_state_t;

endpackage

// File: rtl/instruction_cache_fsm.sv
// Refill controller for the instruction cache.
// Ports:
//   CLOCK, RESET   rising-edge clock, synchronous active-high reset
//   READ, hit      fetch request and lookup result from the top level
//   MEM_BUSYWAIT   instruction memory busy; low = block data valid
//   BUSYWAIT       stall to PC/pipeline
//   MEM_READ       registered block read request to memory
//   start_miss     pulse: a miss is detected in IDLE (latch request block)
//   capture        pulse: memory data valid, load the line buffer
//   update         pulse: write the line buffer into the arrays
module instruction_cache_fsm
  import instruction_cache_pkg::*;
(
  input  logic CLOCK,
  input  logic RESET,
  input  logic READ,
  input  logic hit,
  input  logic MEM_BUSYWAIT,
  output logic BUSYWAIT,
  output logic MEM_READ,
  output logic start_miss,
  output logic capture,
  output logic update
);

  cache_state_t state;

  // BUSYWAIT must fall in the same cycle as a hit, so it is decoded from the
  // state plus the live lookup rather than registered.
  always_comb begin
    start_miss = (state == ST_IDLE) && READ && !hit;
    capture    = (state == ST_MEM_READ) && !MEM_BUSYWAIT;
    update     = (state == ST_UPDATE);
    BUSYWAIT   = start_miss || (state != ST_IDLE);
  end

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge CLOCK) begin
    if (RESET) begin
      state    <= ST_IDLE;
      MEM_READ <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start_miss) begin
            state    <= ST_MEM_READ;
            MEM_READ <= 1'b1;
          end
        end
        ST_MEM_READ: begin
          if (!MEM_BUSYWAIT) begin
            state    <= ST_UPDATE;
            MEM_READ <= 1'b0;
          end
        end
        ST_UPDATE: begin
          state    <= ST_IDLE;
          MEM_READ <= 1'b0;
        end
        default: begin
          state    <= ST_IDLE;
          MEM_READ <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: rtl/instruction_cache.sv
// Direct-mapped, read-only instruction cache between the IF-stage PC and
// the instruction memory. Misses stall the pipeline via BUSYWAIT while a
// whole block is fetched over a block-wide handshake.
// Ports:
//   CLOCK, RESET   rising-edge clock, synchronous active-high reset
//   READ, ADDRESS  fetch request and byte address (bits [1:0] ignored)
//   INSTRUCTION    fetched word, valid when READ && !BUSYWAIT
//   BUSYWAIT       stall to PC/pipeline
//   MEM_READ       block read request to instruction memory
//   MEM_ADDRESS    block address (ADDRESS >> (2+OFFSET_W)), 0 when idle
//   MEM_READDATA   block data, word 0 in the LSBs
//   MEM_BUSYWAIT   memory busy; data valid in the cycle it is low
module instruction_cache
  import instruction_cache_pkg::*;
#(
  parameter int NUM_BLOCKS      = DEFAULT_NUM_BLOCKS,
  parameter int WORDS_PER_BLOCK = DEFAULT_WORDS_PER_BLOCK
) (
  input  logic                                          CLOCK,
  input  logic                                          RESET,
  input  logic                                          READ,
  input  logic [31:0]                                   ADDRESS,
  output logic [31:0]                                   INSTRUCTION,
  output logic                                          BUSYWAIT,
  output logic                                          MEM_READ,
  output logic [32-2-$clog2(WORDS_PER_BLOCK)-1:0]       MEM_ADDRESS,
  input  logic [32*WORDS_PER_BLOCK-1:0]                 MEM_READDATA,
  input  logic                                          MEM_BUSYWAIT
);

  localparam int IDX_BITS  = $clog2(NUM_BLOCKS);
  localparam int OFS_BITS  = $clog2(WORDS_PER_BLOCK);
  localparam int TAG_BITS  = 32 - 2 - OFS_BITS - IDX_BITS;
  localparam int BLK_BITS  = 32 - 2 - OFS_BITS;
  localparam int LINE_BITS = 32 * WORDS_PER_BLOCK;

  // Address fields of the current fetch.
  logic [OFS_BITS-1:0] offset;
  logic [IDX_BITS-1:0] index;
  logic [TAG_BITS-1:0] tag;
  logic [BLK_BITS-1:0] blk_addr;
  logic                unused_byte_bits;

  assign offset           = ADDRESS[2 +: OFS_BITS];
  assign index            = ADDRESS[2+OFS_BITS +: IDX_BITS];
  assign tag              = ADDRESS[31 -: TAG_BITS];
  assign blk_addr         = ADDRESS[31 -: BLK_BITS];
  assign unused_byte_bits = ^ADDRESS[1:0];

  // Storage.
  logic [NUM_BLOCKS-1:0] valid_array;
  logic [TAG_BITS-1:0]   tag_array  [NUM_BLOCKS];
  logic [LINE_BITS-1:0]  data_array [NUM_BLOCKS];
  logic [LINE_BITS-1:0]  line_buf;
  logic [BLK_BITS-1:0]   req_blk;
  logic [IDX_BITS-1:0]   req_index;
  logic [TAG_BITS-1:0]   req_tag;

  assign req_index = req_blk[IDX_BITS-1:0];
  assign req_tag   = req_blk[BLK_BITS-1 -: TAG_BITS];

  // Lookup.
  logic                 hit;
  logic [LINE_BITS-1:0] cur_line;

  assign hit         = valid_array[index] && (tag_array[index] == tag);
  assign cur_line    = data_array[index];
  assign INSTRUCTION = cur_line[32*offset +: 32];

  logic start_miss, capture, update;

  instruction_cache_fsm u_fsm (
    .CLOCK        (CLOCK),
    .RESET        (RESET),
    .READ         (READ),
    .hit          (hit),
    .MEM_BUSYWAIT (MEM_BUSYWAIT),
    .BUSYWAIT     (BUSYWAIT),
    .MEM_READ     (MEM_READ),
    .start_miss   (start_miss),
    .capture      (capture),
    .update       (update)
  );

  assign MEM_ADDRESS = MEM_READ ? req_blk : '0;

  // Control state: valid bits and the outstanding request block.
  always_ff @(posedge CLOCK) begin
    if (RESET) begin
      valid_array <= '0;
      req_blk     <= '0;
    end else begin
      if (start_miss) req_blk <= blk_addr;
      if (update)     valid_array[req_index] <= 1'b1;
    end
  end

  // NOTE: data, tag and line buffer are not reset; valid_array alone decides
  // whether their contents mean anything. RESET still gates the array write
  // so a refill interrupted by reset leaves no line behind.
  always_ff @(posedge CLOCK) begin
    if (capture) line_buf <= MEM_READDATA;
    if (update && !RESET) begin
      data_array[req_index] <= line_buf;
      tag_array[req_index]  <= req_tag;
    end
  end

endmodule
